accel_cmd_master: RTL and testbench

- Bus initiator that drives the memory-mapped multiply accelerator's register interface on behalf of a host.
- Accepts an operand pair on a valid/ready request channel and writes operands A and B.
- Writes the go register, polls the done bit, reads result C, and returns it on a valid/ready response channel.
- Sits between the core-side command path and the accelerator's addr/wr_en/accel_select/data_in/data_out port.

---
 rtl/accel_cmd_master.sv | 221 ++++++++++++++++++++++
 tb/tb_accel_cmd_master.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_cmd_master.sv
// accel_cmd_master: issues one host multiply request at a time over the accelerator register port.
// Latency: rsp_valid 9 cycles after the accepting edge (11 with ACCEL_MASTER_VERIFY_EN defined).
// Backpressure: req_ready only in IDLE (no queueing); RESP holds data/err until rsp_ready.
// Optional feature macro: ACCEL_MASTER_VERIFY_EN adds operand readback checks before the go write.
module accel_cmd_master #(
  parameter logic [31:0] ACC_BASE       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] acc_addr,
  output logic        acc_wr_en,
  output logic        acc_select,
  output logic [31:0] acc_wdata,
  input  logic [31:0] acc_rdata,
  output logic        busy
);

  localparam logic [31:0] OFF_CTRL = 32'h0000_0000;
  localparam logic [31:0] OFF_A    = 32'h0000_0008;
  localparam logic [31:0] OFF_B    = 32'h0000_000C;
  localparam logic [31:0] OFF_C    = 32'h0000_0010;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  // Value of the counter during the last permitted done-less POLL cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_RB_A,
    S_RB_B,
    S_WR_GO,
    S_POLL,
    S_RD_C,
    S_RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   op_b;
`ifdef ACCEL_MASTER_VERIFY_EN
  logic [31:0]   op_a;
`endif
  logic [CW-1:0] poll_cnt;
  logic          done;
  logic          timeout_hit;

  logic          rsp_load;
  logic          rsp_err_nxt;
  logic [31:0]   rsp_data_nxt;

  logic [31:0]   addr_nxt;
  logic [31:0]   wdata_nxt;
  logic          sel_nxt;
  logic          wr_nxt;

  assign done        = acc_rdata[31];
  assign timeout_hit = (poll_cnt >= CNT_LAST);

  // Next-state selection and the response value loaded when entering RESP.
  always_comb begin
    state_nxt    = state;
    rsp_load     = 1'b0;
    rsp_err_nxt  = 1'b0;
    rsp_data_nxt = 32'h0;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_WR_A;
      S_WR_A:  state_nxt = S_WR_B;
`ifdef ACCEL_MASTER_VERIFY_EN
      S_WR_B:  state_nxt = S_RB_A;
      S_RB_A: begin
        if (acc_rdata != op_a) begin
          state_nxt   = S_RESP;
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
        end else begin
          state_nxt = S_RB_B;
        end
      end
      S_RB_B: begin
        if (acc_rdata != op_b) begin
          state_nxt   = S_RESP;
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
        end else begin
          state_nxt = S_WR_GO;
        end
      end
`else
      S_WR_B:  state_nxt = S_WR_GO;
`endif
      S_WR_GO: state_nxt = S_POLL;
      S_POLL: begin
        if (done) begin
          state_nxt = S_RD_C;
        end else if (timeout_hit) begin
          state_nxt   = S_RESP;
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
        end
      end
      S_RD_C: begin
        state_nxt    = S_RESP;
        rsp_load     = 1'b1;
        rsp_data_nxt = acc_rdata;
      end
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus drive for the state about to be entered, so the bus registers mirror the state register.
  always_comb begin
    addr_nxt  = ACC_BASE;
    wdata_nxt = 32'h0;
    sel_nxt   = 1'b0;
    wr_nxt    = 1'b0;
    case (state_nxt)
      S_WR_A: begin
        // WR_A is only ever entered from IDLE, on the accepting edge.
        addr_nxt  = ACC_BASE + OFF_A;
        wdata_nxt = req_a;
        sel_nxt   = 1'b1;
        wr_nxt    = 1'b1;
      end
      S_WR_B: begin
        addr_nxt  = ACC_BASE + OFF_B;
        wdata_nxt = op_b;
        sel_nxt   = 1'b1;
        wr_nxt    = 1'b1;
      end
      S_RB_A: begin
        addr_nxt = ACC_BASE + OFF_A;
        sel_nxt  = 1'b1;
      end
      S_RB_B: begin
        addr_nxt = ACC_BASE + OFF_B;
        sel_nxt  = 1'b1;
      end
      S_WR_GO: begin
        addr_nxt  = ACC_BASE + OFF_CTRL;
        wdata_nxt = 32'h0000_0001;
        sel_nxt   = 1'b1;
        wr_nxt    = 1'b1;
      end
      S_POLL: begin
        addr_nxt = ACC_BASE + OFF_CTRL;
        sel_nxt  = 1'b1;
      end
      S_RD_C: begin
        addr_nxt = ACC_BASE + OFF_C;
        sel_nxt  = 1'b1;
      end
      default: begin
        addr_nxt  = ACC_BASE;
        wdata_nxt = 32'h0;
      end
    endcase
  end

  // State register plus registered handshake, bus, operand, poll-counter and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      rsp_data   <= 32'h0;
      rsp_err    <= 1'b0;
      acc_addr   <= ACC_BASE;
      acc_wdata  <= 32'h0;
      acc_select <= 1'b0;
      acc_wr_en  <= 1'b0;
      op_b       <= 32'h0;
`ifdef ACCEL_MASTER_VERIFY_EN
      op_a       <= 32'h0;
`endif
      poll_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      req_ready  <= (state_nxt == S_IDLE);
      rsp_valid  <= (state_nxt == S_RESP);
      busy       <= (state_nxt != S_IDLE);
      acc_addr   <= addr_nxt;
      acc_wdata  <= wdata_nxt;
      acc_select <= sel_nxt;
      acc_wr_en  <= wr_nxt;

      if (state == S_IDLE && req_valid) begin
        op_b <= req_b;
`ifdef ACCEL_MASTER_VERIFY_EN
        op_a <= req_a;
`endif
      end

      // Counter is zero on POLL entry and saturates rather than wrapping.
      if (state != S_POLL) begin
        poll_cnt <= '0;
      end else if (!done && poll_cnt != CNT_MAX) begin
        poll_cnt <= poll_cnt + CW'(1);
      end

      if (rsp_load) begin
        rsp_data <= rsp_data_nxt;
        rsp_err  <= rsp_err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_accel_cmd_master.sv
// Bench for accel_cmd_master: directed scenarios plus randomized requests, scoreboard-checked.
// An accelerator slave model answers the bus; expected responses come from request-level rules.
// A negedge monitor pops the scoreboard on every response handshake.
module tb_accel_cmd_master;

  localparam logic [31:0] BASE = 32'h8000_1000;
  localparam int TO = 64;
`ifdef ACCEL_MASTER_VERIFY_EN
  localparam int LAT    = 11;
  localparam int GO_GAP = 3;
  localparam bit VERIFY = 1'b1;
`else
  localparam int LAT    = 9;
  localparam int GO_GAP = 1;
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] acc_addr;
  logic        acc_wr_en;
  logic        acc_select;
  logic [31:0] acc_wdata;
  logic [31:0] acc_rdata;
  logic        busy;

  accel_cmd_master #(.ACC_BASE(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .acc_addr(acc_addr), .acc_wr_en(acc_wr_en), .acc_select(acc_select),
    .acc_wdata(acc_wdata), .acc_rdata(acc_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (wait budget expired)", name);
  endtask

  // Accelerator behaviour: each result byte is the truncated product of the operand bytes.
  function automatic logic [31:0] lane_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(a[8*i +: 8] * b[8*i +: 8]);
    return r;
  endfunction

  // ---------------- accelerator slave model ----------------
  logic        never_done = 1'b0;
  logic        corrupt_b  = 1'b0;
  int          done_dly   = 4;
  int          go_writes  = 0;
  logic [31:0] s_a, s_b, s_c;
  logic        s_done;
  int          s_tmr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_a <= 32'h0; s_b <= 32'h0; s_c <= 32'h0; s_done <= 1'b0; s_tmr <= 0;
    end else begin
      if (s_tmr == 1) s_done <= 1'b1;
      if (s_tmr > 0) s_tmr <= s_tmr - 1;
      if (acc_select && acc_wr_en) begin
        case (acc_addr - BASE)
          32'h08: s_a <= acc_wdata;
          32'h0C: s_b <= acc_wdata;
          32'h00: if (acc_wdata[0]) begin
            s_done    <= 1'b0;
            s_c       <= lane_mul(s_a, s_b);
            s_tmr     <= never_done ? 0 : done_dly;
            go_writes <= go_writes + 1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    acc_rdata = 32'h0;
    case (acc_addr - BASE)
      32'h00:  acc_rdata = {s_done, 31'h0};
      32'h08:  acc_rdata = s_a;
      32'h0C:  acc_rdata = corrupt_b ? (s_b ^ 32'h0000_0010) : s_b;
      32'h10:  acc_rdata = s_c;
      default: acc_rdata = 32'h0;
    endcase
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic        lat_en = 1'b0;
  logic        rnd_rdy = 1'b0;
  int          acc_cyc = 0;
  int          hs_cyc = 0;
  int          n_acc = 0;

  // Reference: a request fails if done never comes or (with readback) B reads back wrong.
  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.err  = never_done || (VERIFY && corrupt_b);
    r.data = r.err ? 32'h0 : lane_mul(a, b);
    return r;
  endfunction

  initial begin
    logic prev_valid;
    rsp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_valid && req_ready) begin
          exp_q.push_back(model(req_a, req_b));
          acc_cyc = cyc;
          n_acc++;
        end
        if (rsp_valid && !prev_valid && lat_en) check("latency", cyc - acc_cyc - 1, LAT);
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=%h expected=none", rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
          end
          hs_cyc = cyc;
        end
        if (acc_select && acc_wr_en) begin
          wr_addr_q.push_back(acc_addr);
          wr_data_q.push_back(acc_wdata);
          wr_cyc_q.push_back(cyc);
        end
        prev_valid = rsp_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_a = a; req_b = b;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail_now("send_accept");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string what);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now(what);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rsp_data"}, rsp_data, 32'h0);
    check({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    check({tag, "_acc_wr_en"}, {31'h0, acc_wr_en}, 32'h0);
    check({tag, "_acc_select"}, {31'h0, acc_select}, 32'h0);
    check({tag, "_acc_addr"}, acc_addr, BASE);
    check({tag, "_acc_wdata"}, acc_wdata, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, b;
    int n, pc, na, g0;

    rst_n = 1'b1; req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic transaction with write-sequence inspection.
    lat_en = 1'b1;
    rsp_ready = 1'b1;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    send(32'h0000_0302, 32'h0000_0504);
    wait_done(100, "basic_rsp");
    check("basic_nwrites", wr_addr_q.size(), 3);
    if (wr_addr_q.size() == 3) begin
      check("basic_wr0_addr", wr_addr_q[0], BASE + 32'h08);
      check("basic_wr0_data", wr_data_q[0], 32'h0000_0302);
      check("basic_wr1_addr", wr_addr_q[1], BASE + 32'h0C);
      check("basic_wr1_data", wr_data_q[1], 32'h0000_0504);
      check("basic_wr2_addr", wr_addr_q[2], BASE);
      check("basic_wr2_data", wr_data_q[2], 32'h0000_0001);
      check("basic_gap_ab", wr_cyc_q[1] - wr_cyc_q[0], 1);
      check("basic_gap_bgo", wr_cyc_q[2] - wr_cyc_q[1], GO_GAP);
    end

    // Backpressure: result must hold while rsp_ready is low.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    a = $urandom; b = $urandom;
    send(a, b);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) fail_now("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_rsp_data", rsp_data, lane_mul(a, b));
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_req_ready", {31'h0, req_ready}, 32'h1);
    check("bp_idle_busy", {31'h0, busy}, 32'h0);
    check("bp_idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);

    // Timeout: slave never raises done.
    lat_en = 1'b0;
    never_done = 1'b1;
    send($urandom, $urandom);
    pc = 0; n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      if (acc_select && !acc_wr_en && acc_addr == BASE) pc++;
      n++;
    end
    if (!rsp_valid) fail_now("to_rsp_valid");
    check("to_poll_cycles", pc, TO);
    check("to_acc_select", {31'h0, acc_select}, 32'h0);
    check("to_rsp_err", {31'h0, rsp_err}, 32'h1);
    check("to_rsp_data", rsp_data, 32'h0);
    wait_done(50, "to_rsp");
    never_done = 1'b0;

    // Back-to-back: req_valid held high across the first handshake.
    lat_en = 1'b1;
    na = n_acc;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_a = $urandom; req_b = $urandom;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_a = 32'h0000_0101; req_b = 32'h0000_0202;
    n = 0;
    while (n_acc < na + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n_acc < na + 2) fail_now("b2b_second_accept");
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("b2b_accept_gap", acc_cyc - hs_cyc, 1);
    wait_done(100, "b2b_rsp");

    // Reset during POLL, then a clean transaction.
    send($urandom, $urandom);
    n = 0;
    while (!(acc_select && !acc_wr_en && acc_addr == BASE) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("mid_reach_poll");
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send($urandom, $urandom);
    wait_done(100, "post_reset_rsp");

`ifdef ACCEL_MASTER_VERIFY_EN
    // Corrupted B readback must suppress the go write.
    lat_en = 1'b0;
    corrupt_b = 1'b1;
    g0 = go_writes;
    send($urandom, $urandom);
    wait_done(100, "verify_rsp");
    check("verify_no_go", go_writes, g0);
    corrupt_b = 1'b0;
`else
    g0 = 0;
`endif

    // Randomized traffic with random done delay, occasional timeouts and random backpressure.
    lat_en = 1'b0;
    rnd_rdy = 1'b1;
    for (int t = 0; t < 25; t++) begin
      never_done = ($urandom_range(0, 5) == 0);
      done_dly = $urandom_range(1, 8);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send($urandom, $urandom);
      wait_done(400, "rand_rsp");
    end
    rnd_rdy = 1'b0;
    never_done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
